// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types and constants for the instruction encoder.
// The immediate-format codes match the immediate extender's ImmSrc selection.
package riscv_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_R = 3'b101
    } imm_src_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef struct packed {
        logic [31:0] instr;
        logic        illegal;
        logic        err;
    } enc_word_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: format + fields + immediate -> RV32I word, illegal and range flags.
// Optional immediate range checking is enabled with `define IMM_RANGE_CHECK_EN.
module imm_pack (
    input  logic [2:0]  immsrc,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        err
);
    import riscv_pkg::*;

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (immsrc)
            IMM_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            IMM_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            IMM_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            IMM_U: word = {imm[31:12], rd, opcode};
            IMM_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            IMM_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            default: begin
                word    = NOP;
                illegal = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm);

    always_comb begin
        err = 1'b0;
        case (immsrc)
            IMM_I, IMM_S: err = (simm < -32'sd2048) || (simm > 32'sd2047);
            IMM_B:        err = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            IMM_J:        err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            IMM_U:        err = |imm[11:0];
            default:      err = 1'b0;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepted requests are packed and buffered in a FIFO,
// emitted with a running byte address. Range flag via `define IMM_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_immsrc,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_illegal,
    output logic        out_err
);
    import riscv_pkg::*;

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    enc_word_t enc;
    enc_word_t mem_q [FIFO_DEPTH];
    enc_word_t head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      addr_q, addr_d;
    logic             in_ready_q, in_ready_d;
    logic             head_valid, push, pop;

    imm_pack u_imm_pack (
        .immsrc  (in_immsrc),
        .opcode  (in_opcode),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .imm     (in_imm),
        .word    (enc.instr),
        .illegal (enc.illegal),
        .err     (enc.err)
    );

    assign head_valid = (count_q != '0);
    assign push       = in_valid && in_ready_q;
    assign pop        = head_valid && out_ready;

    // The FIFO slot itself is the registered encode stage; in_ready comes from the
    // next count so a pop never opens the input in the same cycle.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + 32'd4;
        end
        in_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc;
    end

    assign head        = mem_q[rd_ptr_q];
    assign in_ready    = in_ready_q;
    assign out_valid   = head_valid;
    assign out_instr   = head_valid ? head.instr : '0;
    assign out_illegal = head_valid && head.illegal;
    assign out_err     = head_valid && head.err;
    assign out_addr    = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a field-level reference model predicts each accepted
// request; a monitor compares every emitted beat. Honours `define IMM_RANGE_CHECK_EN.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        bit [2:0]  src;
        bit [6:0]  op;
        bit [4:0]  rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [2:0]  f3;
        bit [6:0]  f7;
        bit [31:0] imm;
    } req_t;

    typedef struct {
        bit [31:0] instr;
        bit        illegal;
        bit        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_illegal;
    logic        out_err;

    req_t        cur;
    exp_t        sb[$];
    bit   [31:0] exp_addr;
    bit          rnd_ready;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_immsrc   (cur.src),
        .in_opcode   (cur.op),
        .in_rd       (cur.rd),
        .in_rs1      (cur.rs1),
        .in_rs2      (cur.rs2),
        .in_funct3   (cur.f3),
        .in_funct7   (cur.f7),
        .in_imm      (cur.imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .out_illegal (out_illegal),
        .out_err     (out_err)
    );

    task automatic chk(input string name, input bit [31:0] act, input bit [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: place each field at its bit position by arithmetic on the immediate.
    function automatic exp_t model(input req_t r);
        exp_t      e;
        bit [31:0] imm;
        bit [31:0] w;
        int        s;
        imm = r.imm;
        s = $signed(r.imm);
        e.illegal = 1'b0;
        e.err = 1'b0;
        w = 32'(r.op);
        case (r.src)
            3'd0: begin
                w += (32'(r.rd) << 7) + (32'(r.f3) << 12) + (32'(r.rs1) << 15) + ((imm % 4096) << 20);
                e.err = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                w += ((imm % 32) << 7) + (32'(r.f3) << 12) + (32'(r.rs1) << 15) + (32'(r.rs2) << 20)
                   + (((imm >> 5) % 128) << 25);
                e.err = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w += (((imm >> 11) % 2) << 7) + (((imm >> 1) % 16) << 8) + (32'(r.f3) << 12)
                   + (32'(r.rs1) << 15) + (32'(r.rs2) << 20) + (((imm >> 5) % 64) << 25)
                   + (((imm >> 12) % 2) << 31);
                e.err = (s < -4096) || (s > 4094) || (imm % 2 != 0);
            end
            3'd3: begin
                w += (32'(r.rd) << 7) + (imm - imm % 4096);
                e.err = (imm % 4096 != 0);
            end
            3'd4: begin
                w += (32'(r.rd) << 7) + (((imm >> 12) % 256) << 12) + (((imm >> 11) % 2) << 20)
                   + (((imm >> 1) % 1024) << 21) + (((imm >> 20) % 2) << 31);
                e.err = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (imm % 2 != 0);
            end
            3'd5: begin
                w += (32'(r.rd) << 7) + (32'(r.f3) << 12) + (32'(r.rs1) << 15) + (32'(r.rs2) << 20)
                   + (32'(r.f7) << 25);
            end
            default: begin
                w = 32'h0000_0013;
                e.illegal = 1'b1;
            end
        endcase
`ifndef IMM_RANGE_CHECK_EN
        e.err = 1'b0;
`endif
        e.instr = w;
        return e;
    endfunction

    function automatic req_t mk(input bit [2:0] src, input bit [6:0] op, input bit [4:0] rd,
                                input bit [4:0] rs1, input bit [4:0] rs2, input bit [2:0] f3,
                                input bit [31:0] imm);
        req_t r;
        r.src = src; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = 7'h0; r.imm = imm;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.src = 3'($urandom_range(0, 7));
        r.op  = 7'($urandom);
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        r.f3  = 3'($urandom);
        r.f7  = 7'($urandom);
        case ($urandom_range(0, 3))
            0: r.imm = $urandom;
            1: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: r.imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & ~32'd1;
            default: r.imm = $urandom & 32'hFFFF_F000;
        endcase
        return r;
    endfunction

    // Record accepted requests (handshake is stable at the falling edge).
    initial forever begin
        @(negedge clk);
        if (!reset && in_valid && in_ready) sb.push_back(model(cur));
    end

    // Compare every beat the DUT presents against the scoreboard head.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", out_instr, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    chk("beat_instr", out_instr, e.instr);
                    chk("beat_flags", {30'b0, out_illegal, out_err}, {30'b0, e.illegal, e.err});
                    chk("beat_addr", out_addr, exp_addr);
                    exp_addr += 32'd4;
                end
            end else if (!out_valid) begin
                chk("empty_head", {out_instr[31:2], out_instr[1:0] | {out_illegal, out_err}}, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic rand_rdy();
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input req_t r, output int waited);
        cur = r;
        in_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            @(posedge clk);
            #1;
            rand_rdy();
        end
        chk("accept_timeout", 32'(waited < 40), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rand_rdy();
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        sb.delete();
        exp_addr = BASE;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_addr", out_addr, BASE);
        chk("rst_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        req_t      dir [6];
        bit [31:0] dir_exp [6];
        req_t      extra [3];
        req_t      r;
        int        w;
        int        stalls;
        int        bubbles;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rnd_ready = 1'b0;
        #3;
        do_reset();

        dir[0] = mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd50);        dir_exp[0] = 32'h0320_0093;
        dir[1] = mk(3'd1, 7'h23, 5'd0, 5'd0, 5'd3, 3'd2, 32'hFFFF_FFFC); dir_exp[1] = 32'hFE30_2E23;
        dir[2] = mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd8);         dir_exp[2] = 32'h0000_0463;
        dir[3] = mk(3'd3, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 32'h1000);      dir_exp[3] = 32'h0000_1037;
        dir[4] = mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);         dir_exp[4] = 32'h0000_00EF;
        dir[5] = mk(3'd6, 7'h33, 5'd5, 5'd6, 5'd7, 3'd1, 32'd9);         dir_exp[5] = 32'h0000_0013;

        // Directed words: one-edge latency into an empty FIFO, then pop.
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b0;
            send(dir[i], w);
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("lat_instr", out_instr, dir_exp[i]);
            chk("lat_illegal", 32'(out_illegal), 32'(i == 5));
            drain();
        end

        // Range-check boundaries (flag is zero without the macro).
        extra[0] = mk(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2048);
        extra[1] = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd7);
        extra[2] = mk(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(extra[i], w);
        drain();

        // Fill with output blocked: in_ready drops after the fourth accept.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(rand_req(), w);
            chk("fill_ready", 32'(in_ready), 32'(i < 3));
        end
        r = rand_req();
        cur = r;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_hold", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", 32'(in_ready), 32'd0);
        send(r, w);
        drain();

        // Back-to-back streaming, then reset with a word still pending.
        do_reset();
        out_ready = 1'b1;
        stalls = 0;
        bubbles = 0;
        for (int i = 0; i < 20; i++) begin
            send(rand_req(), w);
            stalls += w;
            if (!out_valid) bubbles++;
        end
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        reset = 1'b1;
        sb.delete();
        exp_addr = BASE;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_instr", out_instr, 32'h0);
        chk("midrst_addr", out_addr, BASE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(dir[0], w);
        chk("post_rst_addr", out_addr, BASE);
        drain();

        // Randomised traffic with random back-pressure and idle gaps.
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            send(rand_req(), w);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                rand_rdy();
            end
        end
        rnd_ready = 1'b0;
        drain();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
